// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// if_stage : instruction-fetch stage with a one-entry skid buffer and flush redirect
// Rev 1.0
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        IF_Flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid,
    output logic [15:0] fetch_stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUF  = 2'd2
    } state_t;

    state_t      r_state,      w_state_nxt;
    logic [31:0] r_pc,         w_pc_nxt;
    logic [31:0] r_ifid_pc,    w_ifid_pc_nxt;
    logic [31:0] r_ifid_instr, w_ifid_instr_nxt;
    logic        r_ifid_valid, w_ifid_valid_nxt;
    logic [31:0] r_buf_pc,     w_buf_pc_nxt;
    logic [31:0] r_buf_instr,  w_buf_instr_nxt;
    logic [15:0] r_stall_cnt,  w_stall_cnt_nxt;
    logic [15:0] w_stall_inc;
    logic [31:0] w_pc_plus4;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_stall_inc = (r_stall_cnt == 16'hFFFF) ? r_stall_cnt : r_stall_cnt + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_ifid_pc    <= 32'd0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            r_buf_pc     <= 32'd0;
            r_buf_instr  <= NOP_INSTR;
            r_stall_cnt  <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
            r_buf_pc     <= w_buf_pc_nxt;
            r_buf_instr  <= w_buf_instr_nxt;
            r_stall_cnt  <= w_stall_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_valid_nxt = r_ifid_valid;
        w_buf_pc_nxt     = r_buf_pc;
        w_buf_instr_nxt  = r_buf_instr;
        w_stall_cnt_nxt  = r_stall_cnt;

        // A flush overrides stalls and acks alike; the buffered word is simply dropped.
        if ((r_state != ST_IDLE) && IF_Flush) begin
            w_state_nxt      = ST_REQ;
            w_pc_nxt         = branch_target & 32'hFFFF_FFFC;
            w_ifid_instr_nxt = NOP_INSTR;
            w_ifid_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        if (IF_ID_Write && PCWrite) begin
                            w_ifid_pc_nxt    = r_pc;
                            w_ifid_instr_nxt = imem_rdata;
                            w_ifid_valid_nxt = 1'b1;
                            w_pc_nxt         = w_pc_plus4;
                        end else begin
                            w_buf_pc_nxt    = r_pc;
                            w_buf_instr_nxt = imem_rdata;
                            w_state_nxt     = ST_BUF;
                        end
                    end else begin
                        w_stall_cnt_nxt = w_stall_inc;
                        if (IF_ID_Write) begin
                            w_ifid_instr_nxt = NOP_INSTR;
                            w_ifid_valid_nxt = 1'b0;
                        end
                    end
                end
                ST_BUF: begin
                    w_stall_cnt_nxt = w_stall_inc;
                    if (IF_ID_Write && PCWrite) begin
                        w_ifid_pc_nxt    = r_buf_pc;
                        w_ifid_instr_nxt = r_buf_instr;
                        w_ifid_valid_nxt = 1'b1;
                        w_pc_nxt         = w_pc_plus4;
                        w_state_nxt      = ST_REQ;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req        = (r_state == ST_REQ);
    assign imem_addr       = r_pc;
    assign IF_ID_PC        = r_ifid_pc;
    assign IF_ID_Instr     = r_ifid_instr;
    assign IF_ID_Valid     = r_ifid_valid;
    assign fetch_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset, word aligned.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: instruction word driven on bubbles (addi x0,x0,0).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 PCWrite  input  1  from hazard unit; 1 = PC may advance.
REQ-006 IF_ID_Write  input  1  from hazard unit; 1 = IF/ID register may load.
REQ-007 IF_Flush  input  1  from hazard unit; 1 = taken branch, redirect fetch.
REQ-008 branch_target  input  32  redirect PC, sampled when IF_Flush=1.
REQ-009 imem_req  output  1  instruction-memory request, registered.
REQ-010 imem_addr  output  32  fetch address, equals current PC.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-012 imem_ack  input  1  memory response; may assert in the same cycle as imem_req or later.
REQ-013 IF_ID_PC  output  32  PC of instruction held in IF/ID.
REQ-014 IF_ID_Instr  output  32  instruction held in IF/ID.
REQ-015 IF_ID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-016 fetch_stall_cnt  output  16  performance counter of stalled fetch cycles.

Function
REQ-017 State machine with states IDLE, REQ, BUF; imem_req SHALL be 1 exactly when state is REQ.
REQ-018 IDLE -> REQ unconditionally on first clock edge after rst_n rises.
REQ-019 REQ, imem_ack=1, IF_ID_Write=1, PCWrite=1: IF/ID loads {PC, imem_rdata, Valid=1}, PC <= PC+4, stay REQ.
REQ-020 REQ, imem_ack=1, IF_ID_Write=0: imem_rdata and PC captured in internal buffer, PC unchanged, go to BUF.
REQ-021 REQ, imem_ack=0, IF_ID_Write=1: IF/ID loads bubble (Valid=0, Instr=NOP_INSTR, PC unchanged), stay REQ.
REQ-022 REQ, imem_ack=0, IF_ID_Write=0: IF/ID and PC hold, stay REQ.
REQ-023 BUF, IF_ID_Write=1 and PCWrite=1: buffer moves into IF/ID with Valid=1, PC <= PC+4, go to REQ; otherwise everything holds in BUF.
REQ-024 IF_Flush=1 SHALL take priority over every other input in every non-IDLE state: PC <= {branch_target[31:2],2'b00}, IF/ID loads bubble, buffer discarded, next state REQ.
REQ-025 IF_Flush=1 SHALL redirect even when PCWrite=0 and IF_ID_Write=0 in the same cycle.
REQ-026 A request without ack when the address changes is abandoned; memory SHALL return data for the address present in the ack cycle.
REQ-027 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-028 imem_ack while not in REQ SHALL be ignored.
REQ-029 fetch_stall_cnt SHALL increment by 1 each cycle in REQ with imem_ack=0 or in BUF, excluding flush cycles, and saturate at 16'hFFFF.
REQ-030 IF/ID to decode latency SHALL be 1 cycle after ack, or 0 added cycles from BUF when IF_ID_Write returns.

Reset
REQ-031 While rst_n=0: state IDLE, PC=RESET_PC, imem_req=0, IF_ID_PC=0, IF_ID_Instr=NOP_INSTR, IF_ID_Valid=0, buffer empty, fetch_stall_cnt=0.
REQ-032 Reset asserted mid-operation SHALL take effect immediately, discarding any buffered or in-flight fetch.

Verification
REQ-033 Reset release, ack every cycle, rdata = addr -> imem_req=1 from cycle 1; IF_ID_PC sequence 0,4,8,12 with Valid=1; stall count 0.
REQ-034 Ack at PC=8, IF_ID_Write=0 and PCWrite=0 for 2 cycles -> state BUF, imem_req=0, IF/ID holds PC 4; on release IF_ID_PC=8, next fetch addr 12; stall count +2.
REQ-035 IF_Flush=1 with branch_target=32'h0000_0103 during stall -> next imem_addr=32'h0000_0100, IF_ID_Valid=0, IF_ID_Instr=32'h0000_0013.
REQ-036 imem_ack held 0 for 3 cycles at PC=16 -> three bubbles, imem_addr stays 16, stall count +3.
REQ-037 RESET_PC=32'hFFFF_FFF8, ack every cycle -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst_n dropped asynchronously while in BUF -> outputs reach reset values before next clock edge; after release fetch restarts at RESET_PC.
